// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 keyboard scan-code receiver with prefix decode and entry FIFO
module ps2_scan_receiver #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       clk_kb,
  input  logic       data_kb,
  input  logic       rd_en,
  input  logic       clr_ovf,
  output logic [7:0] KeyCode,
  output logic       key_rel,
  output logic       key_ext,
  output logic       valid,
  output logic       overflow,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // synchronizer and filter state
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f;
  logic [FW-1:0] flt_cnt;
  logic          fall;
  logic          fall_dat;

  // frame decoder state
  state_t        state, state_nxt;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          par_bit;
  logic [TW-1:0] tout;
  logic          pend_ext, pend_rel;
  logic          err, done;

  // write request into the entry queue, one cycle after the stop edge
  logic          wr_req;
  logic [9:0]    wr_data;

  // entry queue
  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic          empty, full, pop, push, ovf_set;
  logic [9:0]    head;

  // Two-flop synchronizers for the asynchronous PS/2 lines, idle high
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= clk_kb;
      clk_s2 <= clk_s1;
      dat_s1 <= data_kb;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: accept a new clk level after FILTER_LEN consecutive samples, flag 1->0 changes
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      clk_f    <= 1'b1;
      flt_cnt  <= '0;
      fall     <= 1'b0;
      fall_dat <= 1'b1;
    end else begin
      fall     <= 1'b0;
      fall_dat <= dat_s2;
      if (clk_s2 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FMAX) begin
        clk_f   <= clk_s2;
        flt_cnt <= '0;
        fall    <= clk_f & ~clk_s2;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  // Frame state register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: one step per falling edge, timeout aborts a partial frame
  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    done      = 1'b0;
    if (fall) begin
      case (state)
        S_IDLE: begin
          if (!fall_dat) state_nxt = S_DATA;
          else           err       = 1'b1;
        end
        S_DATA: begin
          if (bitcnt == 3'd7) state_nxt = S_PARITY;
        end
        S_PARITY: state_nxt = S_STOP;
        S_STOP: begin
          state_nxt = S_IDLE;
          if (fall_dat && (^{shreg, par_bit})) done = 1'b1;
          else                                 err  = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (state != S_IDLE && tout == TMAX) begin
      state_nxt = S_IDLE;
      err       = 1'b1;
    end
  end

  // Frame datapath: shift register, parity capture, timeout counter, prefix flags
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      shreg     <= '0;
      bitcnt    <= '0;
      par_bit   <= 1'b0;
      tout      <= '0;
      pend_ext  <= 1'b0;
      pend_rel  <= 1'b0;
      wr_req    <= 1'b0;
      wr_data   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_req    <= 1'b0;
      frame_err <= err;
      if (fall || state == S_IDLE) tout <= '0;
      else                         tout <= tout + 1'b1;
      if (fall) begin
        case (state)
          S_IDLE:   bitcnt <= '0;
          S_DATA: begin
            shreg  <= {fall_dat, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
          end
          S_PARITY: par_bit <= fall_dat;
          default: ;
        endcase
      end
      if (done) begin
        if (shreg == 8'hE0) begin
          pend_ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          pend_rel <= 1'b1;
        end else begin
          wr_req   <= 1'b1;
          wr_data  <= {pend_ext, pend_rel, shreg};
          pend_ext <= 1'b0;
          pend_rel <= 1'b0;
        end
      end
    end
  end

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop     = rd_en & ~empty;
  assign push    = wr_req & (~full | pop);
  assign ovf_set = wr_req & full & ~pop;
  assign head    = mem[rp[AW-1:0]];

  // Queue storage; a push while full and popping reuses the slot being freed
  always_ff @(posedge Clk) begin
    if (push) mem[wp[AW-1:0]] <= wr_data;
  end

  // Queue pointers and sticky overflow (set has priority over clear)
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Show-ahead head entry, forced to zero when the queue is empty
  always_comb begin
    valid   = ~empty;
    KeyCode = 8'h00;
    key_rel = 1'b0;
    key_ext = 1'b0;
    if (!empty) begin
      KeyCode = head[7:0];
      key_rel = head[8];
      key_ext = head[9];
    end
  end

endmodule

// File: doc/ps2_scan_receiver.md
PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal Clk samples required to accept a clk_kb level change.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000: Clk cycles without a clk_kb falling edge before a partial frame is aborted.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: number of decoded key entries buffered; power of two.
REQ-004 SHALL have port Clk, input, 1: system clock, all state on rising edge.
REQ-005 SHALL have port Rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port clk_kb, input, 1: PS/2 clock, asynchronous to Clk.
REQ-007 SHALL have port data_kb, input, 1: PS/2 data, asynchronous to Clk.
REQ-008 SHALL have port rd_en, input, 1: pop head entry when high for one Clk cycle.
REQ-009 SHALL have port clr_ovf, input, 1: clear sticky overflow.
REQ-010 SHALL have port KeyCode, output, 8: scan code of FIFO head entry (show-ahead).
REQ-011 SHALL have port key_rel, output, 1: head entry is a release (F0-prefixed).
REQ-012 SHALL have port key_ext, output, 1: head entry is extended (E0-prefixed).
REQ-013 SHALL have port valid, output, 1: FIFO not empty.
REQ-014 SHALL have port overflow, output, 1: sticky, an entry was dropped because the FIFO was full.
REQ-015 SHALL have port frame_err, output, 1: one-cycle pulse on parity, start or stop error, or timeout.

Function
REQ-016 SHALL pass clk_kb and data_kb through 2-flop synchronizers before any use.
REQ-017 SHALL detect a falling edge only when the filtered clk_kb changes 1->0 after FILTER_LEN equal samples.
REQ-018 SHALL implement FSM IDLE->DATA->PARITY->STOP->IDLE, advancing one state per falling edge; DATA consumes 8 edges.
REQ-019 SHALL leave IDLE only on an edge sampling data_kb=0 (start bit); an edge sampling 1 in IDLE pulses frame_err and stays in IDLE.
REQ-020 SHALL shift data bits LSB-first into an 8-bit register.
REQ-021 SHALL require odd parity over 8 data bits plus the parity bit, and stop bit = 1; on failure, pulse frame_err, discard the byte and leave prefix flags unchanged.
REQ-022 SHALL, outside IDLE, abort to IDLE with a frame_err pulse when TIMEOUT_CYC cycles pass without an edge; the counter resets on every edge.
REQ-023 SHALL treat good byte 0xE0 as setting pend_ext and 0xF0 as setting pend_rel, with no FIFO write.
REQ-024 SHALL, for any other good byte, write {pend_ext, pend_rel, byte} to the FIFO and clear both pend flags.
REQ-025 SHALL write the FIFO on the Clk cycle after the stop-bit edge; valid/KeyCode SHALL update on the next cycle.
REQ-026 SHALL, when rd_en=1 and valid=0, do nothing (no underflow, pointers unchanged).
REQ-027 SHALL, on a write while full with rd_en=0, drop the new entry and set overflow.
REQ-028 SHALL, on a simultaneous write and rd_en while full, pop the head and accept the new entry, with overflow unchanged.
REQ-029 SHALL hold overflow until a cycle with clr_ovf=1; if set and clear coincide, set wins.
REQ-030 SHALL use read/write pointers of log2(FIFO_DEPTH)+1 bits, wrapping modulo 2*FIFO_DEPTH.
REQ-031 SHALL drive KeyCode/key_rel/key_ext = 0 when valid=0.

Reset
REQ-032 SHALL, on Rst=0, immediately set FSM=IDLE, empty the FIFO, and clear pend flags, timeout counter, filter, and synchronizers to idle-high.
REQ-033 SHALL, after reset, hold all outputs at 0 (KeyCode=0x00, key_rel=0, key_ext=0, valid=0, overflow=0, frame_err=0).
REQ-034 SHALL discard a frame in progress when reset is asserted; the first frame after release decodes normally.

Verification
REQ-035 SHALL verify: frame 0x1C, parity 0 -> valid=1, KeyCode=0x1C, rel=0, ext=0; rd_en pulse -> valid=0.
REQ-036 SHALL verify: frames F0,1C -> exactly one entry {ext0,rel1,0x1C}; frames E0,F0,75 -> one entry {ext1,rel1,0x75}.
REQ-037 SHALL verify: 0x1C with parity 1 -> one frame_err pulse and no entry; the following good 0x1C is accepted.
REQ-038 SHALL verify: 5 frames with no reads -> 4 entries (first 4 codes, in order), overflow=1; clr_ovf -> overflow=0.
REQ-039 SHALL verify: start plus 3 data bits, then idle > TIMEOUT_CYC -> frame_err pulse, IDLE; the next 0x32 frame decodes correctly.
REQ-040 SHALL verify: Rst low mid-frame, after the 5th bit, with 2 entries queued -> valid=0, all outputs 0; the next frame 0x1C yields a single entry.
